// File: rtl/cordic_pipe_mv.sv
// ---------------------------------------------------------------------------------------------
// cordic_pipe_mv
//
// Fully pipelined CORDIC engine with a per-sample mode bit.
//   ROTATE (mode 0): rotates (x, y) by the binary angle z. z is driven towards 0.
//   VECTOR (mode 1): drives y towards 0. x becomes the magnitude and z accumulates
//                    in_z + atan2(y, x).
// Results carry the CORDIC gain K ~= 1.6468; nothing inside compensates for it.
// Accepts one sample per cycle. Stage 0 is a registered quadrant pre-rotation and is followed
// by STG micro-rotation stages, so latency is STG+1 cycles. The last stage register is the
// output register. One clock enable stalls the whole pipe whenever the output holds a result
// that downstream does not take.
//
// Parameters
//   DW   signed input width of x/y; internal and output width is DW+2
//   STG  number of micro-rotation iterations, 1..31
//   TW   width of the pass-through tag
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid_i  input sample valid
//   in_ready_o  engine accepts a sample this cycle (combinational)
//   in_mode_i   0 = ROTATE, 1 = VECTOR
//   in_x_i      signed x, DW bits
//   in_y_i      signed y, DW bits
//   in_z_i      binary angle, 2^32 = full turn (0x4000_0000 = +90 deg)
//   in_tag_i    user tag that travels with the sample
//   out_valid_o result valid
//   out_ready_i downstream accepts the result
//   out_mode_o  mode of the result
//   out_x_o     signed x result, DW+2 bits
//   out_y_o     signed y result, DW+2 bits
//   out_z_o     angle result
//   out_tag_o   tag of the result
// ---------------------------------------------------------------------------------------------
module cordic_pipe_mv #(
    parameter int unsigned DW  = 16,
    parameter int unsigned STG = 16,
    parameter int unsigned TW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_mode_i,
    input  logic signed [DW-1:0]   in_x_i,
    input  logic signed [DW-1:0]   in_y_i,
    input  logic        [31:0]     in_z_i,
    input  logic        [TW-1:0]   in_tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_mode_o,
    output logic signed [DW+1:0]   out_x_o,
    output logic signed [DW+1:0]   out_y_o,
    output logic        [31:0]     out_z_o,
    output logic        [TW-1:0]   out_tag_o
);

    // Two guard bits: K * sqrt(2) * 2^(DW-1) < 2^(DW+1), so x/y never overflow.
    localparam int unsigned XW = DW + 2;

    localparam logic [31:0] QuarterTurn = 32'h4000_0000;

    // round(atan(2^-i) * 2^31 / pi), i = 0..30
    localparam logic [31:0] AtanTable [31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001
    };

    if (STG < 1 || STG > 31) begin : g_bad_stg
        $error("cordic_pipe_mv: STG must be in 1..31");
    end

    // Index 0 is the pre-rotation register, index STG is the output register.
    logic signed [XW-1:0] x_q   [STG+1];
    logic signed [XW-1:0] x_d   [STG+1];
    logic signed [XW-1:0] y_q   [STG+1];
    logic signed [XW-1:0] y_d   [STG+1];
    logic        [31:0]   z_q   [STG+1];
    logic        [31:0]   z_d   [STG+1];
    logic        [TW-1:0] tag_q [STG+1];
    logic        [TW-1:0] tag_d [STG+1];
    logic        [STG:0]  vld_q;
    logic        [STG:0]  vld_d;
    logic        [STG:0]  mode_q;
    logic        [STG:0]  mode_d;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] y_ext;
    logic        [STG-1:0] dir;
    logic                 ce;

    // The pipe only stalls when the output register holds an unconsumed result.
    assign ce         = ~vld_q[STG] | out_ready_i;
    assign in_ready_o = ce;

    always_comb begin
        x_ext = {{2{in_x_i[DW-1]}}, in_x_i};
        y_ext = {{2{in_y_i[DW-1]}}, in_y_i};
        dir   = '0;

        // Stage 0: quadrant pre-rotation so the micro-rotations only have to cover +-90 deg.
        x_d[0]    = x_ext;
        y_d[0]    = y_ext;
        z_d[0]    = in_z_i;
        mode_d[0] = in_mode_i;
        tag_d[0]  = in_tag_i;
        vld_d[0]  = in_valid_i;

        if (in_mode_i) begin
            if (x_ext[XW-1]) begin
                if (!y_ext[XW-1]) begin
                    // Quadrant II: rotate by -90 deg, remember +90 deg.
                    x_d[0] = y_ext;
                    y_d[0] = -x_ext;
                    z_d[0] = in_z_i + QuarterTurn;
                end else begin
                    // Quadrant III: rotate by +90 deg, remember -90 deg.
                    x_d[0] = -y_ext;
                    y_d[0] = x_ext;
                    z_d[0] = in_z_i - QuarterTurn;
                end
            end
        end else begin
            unique case (in_z_i[31:30])
                2'b01: begin
                    x_d[0] = -y_ext;
                    y_d[0] = x_ext;
                    z_d[0] = in_z_i - QuarterTurn;
                end
                2'b10: begin
                    x_d[0] = y_ext;
                    y_d[0] = -x_ext;
                    z_d[0] = in_z_i + QuarterTurn;
                end
                default: begin
                end
            endcase
        end

        // Micro-rotations. dir = 1 rotates counter-clockwise by atan(2^-i).
        for (int i = 0; i < STG; i++) begin
            dir[i] = mode_q[i] ? y_q[i][XW-1] : ~z_q[i][31];
            if (dir[i]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - AtanTable[i];
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + AtanTable[i];
            end
            mode_d[i+1] = mode_q[i];
            tag_d[i+1]  = tag_q[i];
            vld_d[i+1]  = vld_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int i = 0; i <= STG; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                z_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else if (ce) begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            for (int i = 0; i <= STG; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                z_q[i]   <= z_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_valid_o = vld_q[STG];
    assign out_mode_o  = mode_q[STG];
    assign out_x_o     = x_q[STG];
    assign out_y_o     = y_q[STG];
    assign out_z_o     = z_q[STG];
    assign out_tag_o   = tag_q[STG];

endmodule

// File: tb/tb_cordic_pipe_mv.sv
// ---------------------------------------------------------------------------------------------
// tb_cordic_pipe_mv
//
// Bench for cordic_pipe_mv (DW=16, STG=16, TW=4). A negedge monitor records every accepted
// sample and checks every valid output against an ideal real-arithmetic model (trig of the
// input angle times the CORDIC gain) with an error tolerance, plus exact order, tag, mode,
// latency (17 cycles plus stall cycles), hold-while-stalled and the in_ready rule.
// Directed cases pin the model with hand-computed numbers.
// ---------------------------------------------------------------------------------------------
module tb_cordic_pipe_mv;

    localparam real PI = 3.14159265358979;
    localparam int  LAT = 17;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic signed [15:0]  in_x;
    logic signed [15:0]  in_y;
    logic        [31:0]  in_z;
    logic        [3:0]   in_tag;
    logic                out_valid;
    logic                out_ready;
    logic                out_mode;
    logic signed [17:0]  out_x;
    logic signed [17:0]  out_y;
    logic        [31:0]  out_z;
    logic        [3:0]   out_tag;

    cordic_pipe_mv #(
        .DW  (16),
        .STG (16),
        .TW  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mode_i   (in_mode),
        .in_x_i      (in_x),
        .in_y_i      (in_y),
        .in_z_i      (in_z),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_mode_o  (out_mode),
        .out_x_o     (out_x),
        .out_y_o     (out_y),
        .out_z_o     (out_z),
        .out_tag_o   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        m;
        int        x;
        int        y;
        bit [31:0] z;
        bit [3:0]  tag;
        int        acc_cyc;
        int        acc_stall;
    } smp_t;

    smp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   n_out = 0;
    real  kgain;

    logic               hold_prev = 1'b0;
    logic signed [17:0] hx, hy;
    logic        [31:0] hz;
    logic        [3:0]  ht;
    logic               hm;

    task automatic chk(input string name, input real act, input real expv, input real tol);
        real d;
        n_chk++;
        d = act - expv;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0.2f, want %0.2f (+-%0.2f) at %0t", name, act, expv, tol,
                     $time);
        end
    endtask

    // Ideal results from the sample's own numbers; z is compared as a wrapped difference.
    task automatic model(input smp_t s, output real ex, output real ey, output bit [31:0] ez,
                         output real txy, output real tz, output bit zvalid);
        real    th, mag, zr;
        longint zl;
        mag    = $sqrt($itor(s.x) * $itor(s.x) + $itor(s.y) * $itor(s.y));
        txy    = 8.0 + kgain * mag / 16384.0;
        zvalid = 1'b1;
        if (!s.m) begin
            th = $itor($signed(s.z)) * PI / (2.0 ** 31);
            ex = kgain * ($itor(s.x) * $cos(th) - $itor(s.y) * $sin(th));
            ey = kgain * ($itor(s.x) * $sin(th) + $itor(s.y) * $cos(th));
            zr = 0.0;
            tz = 2.0 ** 17;
        end else begin
            ex = kgain * mag;
            ey = 0.0;
            zr = $itor($signed(s.z)) + $atan2($itor(s.y), $itor(s.x)) * (2.0 ** 31) / PI;
            if (mag < 32.0) begin
                zvalid = 1'b0;
                tz     = 0.0;
            end else begin
                tz = 2.0 ** 17 + (8.0 / (kgain * mag)) * (2.0 ** 31) / PI;
            end
        end
        zl = longint'(zr);
        ez = zl[31:0];
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        smp_t      s;
        real       ex, ey, txy, tz;
        bit [31:0] ez;
        bit        zv;
        int        dz;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            chk("reset_out_valid", out_valid, 0, 0);
        end else begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready), 0);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1, 0);
                chk("hold_x", out_x, hx, 0);
                chk("hold_y", out_y, hy, 0);
                chk("hold_z", out_z, hz, 0);
                chk("hold_tag", out_tag, ht, 0);
                chk("hold_mode", out_mode, hm, 0);
            end
            if (out_valid) begin
                chk("out_has_expected", exp_q.size() > 0, 1, 0);
                if (exp_q.size() > 0) begin
                    s = exp_q[0];
                    model(s, ex, ey, ez, txy, tz, zv);
                    chk("out_mode", out_mode, s.m, 0);
                    chk("out_tag", out_tag, s.tag, 0);
                    chk("latency", cyc - s.acc_cyc, LAT + stall_cnt - s.acc_stall, 0);
                    chk("out_x", out_x, ex, txy);
                    chk("out_y", out_y, ey, txy);
                    if (zv) begin
                        dz = $signed(out_z - ez);
                        chk("out_z", dz, 0, tz);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            hold_prev = out_valid && !out_ready;
            hx = out_x; hy = out_y; hz = out_z; ht = out_tag; hm = out_mode;
            if (in_valid && in_ready) begin
                s.m = in_mode; s.x = in_x; s.y = in_y; s.z = in_z; s.tag = in_tag;
                s.acc_cyc = cyc; s.acc_stall = stall_cnt;
                exp_q.push_back(s);
            end
        end
    end

    // Presents one sample from posedge+1 and returns at posedge+1 after it was accepted.
    task automatic send(input bit m, input int x, input int y, input bit [31:0] z,
                        input bit [3:0] tag);
        bit acc = 1'b0;
        in_valid = 1'b1; in_mode = m; in_x = 16'(x); in_y = 16'(y); in_z = z; in_tag = tag;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1, 0);
    endtask

    task automatic run_one(input bit m, input int x, input int y, input bit [31:0] z,
                           output int ox, output int oy, output bit [31:0] oz,
                           output int lat);
        send(m, x, y, z, 4'hA);
        in_valid = 1'b0;
        lat = 0; ox = 0; oy = 0; oz = '0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; ox = int'(out_x); oy = int'(out_y); oz = out_z;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        chk("drain_empty", exp_q.size(), 0, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int        ox, oy, lat, base;
        bit [31:0] oz;
        bit        done;

        kgain = 1.0;
        for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_in_ready", in_ready, 1, 0);
        chk("rst_out_x", out_x, 0, 0);
        chk("rst_out_y", out_y, 0, 0);
        chk("rst_out_z", out_z, 0, 0);
        chk("rst_out_mode", out_mode, 0, 0);
        chk("rst_out_tag", out_tag, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 10000 rotated by 45 deg -> 10000*K/sqrt(2) on both axes
        run_one(1'b0, 10000, 0, 32'h2000_0000, ox, oy, oz, lat);
        chk("t1_latency", lat, 17, 0);
        chk("t1_x", ox, 11645, 3);
        chk("t1_y", oy, 11645, 3);
        chk("t1_z", $signed(oz), 0, 2.0 ** 17);

        // 2: vector of (-10000, 0) -> magnitude 10000*K, angle 180 deg
        run_one(1'b1, -10000, 0, 32'h0, ox, oy, oz, lat);
        chk("t2_latency", lat, 17, 0);
        chk("t2_x", ox, 16468, 3);
        chk("t2_y", oy, 0, 3);
        chk("t2_z", $signed(oz - 32'h8000_0000), 0, 2.0 ** 17);

        // 3: (-32768, -32768) rotated by 135 deg -> on the +x axis, ideal 46341*K = 76313
        run_one(1'b0, -32768, -32768, 32'h6000_0000, ox, oy, oz, lat);
        chk("t3_x", ox, 76315, 6);
        chk("t3_y", oy, 0, 4);

        // 4: 64 back-to-back, alternating mode, tag = index
        base = n_out;
        for (int i = 0; i < 64; i++) send(i[0], rnd16(), rnd16(), $urandom(), i[3:0]);
        in_valid = 1'b0;
        drain();
        chk("t4_count", n_out - base, 64, 0);

        // 5: downstream stall for 10 cycles mid-stream
        base = n_out;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send($urandom_range(0, 1) == 1, rnd16(), rnd16(), $urandom(), i[3:0]);
                in_valid = 1'b0;
            end
            begin
                repeat (20) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("t5_in_ready_low", in_ready, 0, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t5_count", n_out - base, 30, 0);

        // 6: reset with 5 samples in flight
        base = n_out;
        for (int i = 0; i < 5; i++) send(1'b0, rnd16(), rnd16(), $urandom(), 4'(i + 3));
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", out_valid, 0, 0);
        chk("t6_out_x_clear", out_x, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one(1'b1, -10000, 0, 32'h0, ox, oy, oz, lat);
        chk("t6_latency", lat, 17, 0);
        chk("t6_x", ox, 16468, 3);
        drain();
        chk("t6_count", n_out - base, 1, 0);

        // 7: random bubbles and random backpressure
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, 1) == 1, rnd16(), rnd16(), $urandom(), 4'(i));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t7_count", n_out - base, 120, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
